// File: rtl/weight_buffer_pp.sv
// Ping-pong weight buffer: one bank fills from the memory side while the other drains to the PE array.
// Bank ownership moves between the two sides through the write_done/read_done handshakes.
module weight_buffer_pp #(
    parameter int RD_WIDTH      = 16,
    parameter int WR_WIDTH      = 64,
    parameter int WR_ADDR_WIDTH = 5,
    parameter int RD_ADDR_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     write_req,
    input  logic [WR_ADDR_WIDTH-1:0] write_addr,
    input  logic [WR_WIDTH-1:0]      write_data,
    input  logic                     write_done,
    output logic                     write_ready,
    input  logic                     read_req,
    input  logic [RD_ADDR_WIDTH-1:0] read_addr,
    input  logic                     read_done,
    output logic                     read_ready,
    output logic [RD_WIDTH-1:0]      read_data,
    output logic                     read_valid,
    output logic                     wr_bank_id,
    output logic                     rd_bank_id
);

    localparam int RATIO = WR_WIDTH / RD_WIDTH;
    localparam int SEL_W = $clog2(RATIO);
    localparam int DEPTH = 1 << WR_ADDR_WIDTH;

    // Both banks share one array; the bank pointer is the top address bit.
    logic [WR_WIDTH-1:0]      r_mem [2*DEPTH];

    logic [1:0]               r_full;
    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic [RD_WIDTH-1:0]      r_read_data;
    logic                     r_read_valid;

    logic                     w_write_ready;
    logic                     w_read_ready;
    logic                     w_wr_acc;
    logic                     w_wdone_acc;
    logic                     w_rd_acc;
    logic                     w_rdone_acc;
    logic [1:0]               w_full_nxt;
    logic [WR_ADDR_WIDTH-1:0] w_rd_word_addr;
    logic [WR_WIDTH-1:0]      w_rd_word;
    logic [RD_WIDTH-1:0]      w_rd_slice;

    assign w_write_ready = ~r_full[r_wr_bank];
    assign w_read_ready  = r_full[r_rd_bank];

    assign w_wr_acc    = write_req  & w_write_ready;
    assign w_wdone_acc = write_done & w_write_ready;
    assign w_rd_acc    = read_req   & w_read_ready;
    assign w_rdone_acc = read_done  & w_read_ready;

    assign w_rd_word_addr = read_addr[RD_ADDR_WIDTH-1:SEL_W];
    assign w_rd_word      = r_mem[{r_rd_bank, w_rd_word_addr}];

    generate
        if (SEL_W == 0) begin : g_no_slice
            assign w_rd_slice = w_rd_word[RD_WIDTH-1:0];
        end else begin : g_slice
            logic [RATIO-1:0][RD_WIDTH-1:0] w_slices;
            logic [SEL_W-1:0]               w_sel;
            assign w_slices   = w_rd_word;
            assign w_sel      = read_addr[SEL_W-1:0];
            assign w_rd_slice = w_slices[w_sel];
        end
    endgenerate

    // write_done and read_done never target the same bank when both are accepted.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wdone_acc) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rdone_acc) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[{r_wr_bank, write_addr}] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_full       <= w_full_nxt;
            r_wr_bank    <= r_wr_bank ^ w_wdone_acc;
            r_rd_bank    <= r_rd_bank ^ w_rdone_acc;
            r_read_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_read_data <= w_rd_slice;
            end
        end
    end

    assign write_ready = w_write_ready;
    assign read_ready  = w_read_ready;
    assign read_data   = r_read_data;
    assign read_valid  = r_read_valid;
    assign wr_bank_id  = r_wr_bank;
    assign rd_bank_id  = r_rd_bank;

endmodule

// File: doc/weight_buffer_pp.md
# weight_buffer_pp

Double-buffered (ping-pong) weight buffer. The write side fills one bank with WR_WIDTH words from the memory interface while the PE array reads RD_WIDTH slices from the other bank. It is the parametrised successor to the single-bank weight buffer. It adds bank-level handshakes, so weight prefetch for layer N+1 overlaps compute on layer N.

## Interface
- RD_WIDTH, 16, read slice width in bits
- WR_WIDTH, 64, write word width in bits; WR_WIDTH/RD_WIDTH = RATIO, must be a power of 2 and at least 1
- WR_ADDR_WIDTH, 5, write word address width; each bank holds 2^WR_ADDR_WIDTH words
- RD_ADDR_WIDTH, 7, read slice address width; must equal WR_ADDR_WIDTH + log2(RATIO)
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- write_req  in  1  write write_data to write_addr in the fill bank
- write_addr  in  WR_ADDR_WIDTH  word address in the fill bank
- write_data  in  WR_WIDTH  write word
- write_done  in  1  fill bank complete; hand it to the read side
- write_ready  out  1  fill bank is free, so writes and write_done are accepted
- read_req  in  1  read the slice at read_addr from the drain bank
- read_addr  in  RD_ADDR_WIDTH  slice address in the drain bank
- read_done  in  1  drain bank consumed; release it to the write side
- read_ready  out  1  drain bank is full, so reads and read_done are accepted
- read_data  out  RD_WIDTH  registered slice
- read_valid  out  1  read_data updated this cycle
- wr_bank_id  out  1  bank currently targeted by writes (debug)
- rd_bank_id  out  1  bank currently targeted by reads (debug)

## Operation
- Storage: two banks, each 2^WR_ADDR_WIDTH x WR_WIDTH. Contents are not reset.
- Per-bank state: full[b]. Pointers: wr_bank and rd_bank.
- write_ready = !full[wr_bank]; read_ready = full[rd_bank].
- Accepted write: write_req && write_ready. mem[wr_bank][write_addr] <= write_data.
- write_req while !write_ready: ignored; memory unchanged.
- Accepted write_done: write_done && write_ready. Sets full[wr_bank]=1 and toggles wr_bank. A write accepted in the same cycle lands in the old bank.
- write_done while !write_ready: ignored.
- Accepted read: read_req && read_ready.
  - Word select: read_addr[RD_ADDR_WIDTH-1:log2(RATIO)].
  - Slice select: read_addr[log2(RATIO)-1:0]. Slice k is word bits [k*RD_WIDTH +: RD_WIDTH], so slice 0 is the LSBs.
- read_req while !read_ready: no access; read_valid=0 the next cycle.
- Accepted read_done: read_done && read_ready. Clears full[rd_bank] and toggles rd_bank. A read accepted in the same cycle returns data from the old bank.
- read_done while !read_ready: ignored.
- Simultaneous accepted write_done and read_done: both take effect. They always act on different banks, because when wr_bank==rd_bank exactly one of write_ready/read_ready is high.
- Bank states cycle empty -> filling -> full -> draining -> empty. At most two banks are in flight at once.
- When RATIO=1, the slice-select logic is absent and read_addr is the word address.

## Timing
- Reset (reset_n low, asynchronous):
  - full = 2'b00, wr_bank = 0, rd_bank = 0.
  - write_ready = 1, read_ready = 0.
  - read_valid = 0, read_data = 0.
  - wr_bank_id = 0, rd_bank_id = 0.
- Read latency is 1 cycle. A read accepted at edge N gives read_data/read_valid at N+1.
- read_data holds its value when no read is accepted. read_valid is a one-cycle pulse per accepted read.
- write_done accepted at edge N: read_ready rises after edge N when rd_bank==that bank. A read accepted at N+1 sees every write accepted at or before N.
- read_done accepted at edge N: write_ready rises after edge N when wr_bank==that bank.
- Back-to-back reads and writes are accepted every cycle; there are no bubbles.
- Reset asserted mid-transfer discards all bank state immediately and any pending read_valid. Memory contents persist but are treated as invalid.

## Test plan
- Reset check: assert reset_n=0 mid-run -> write_ready=1, read_ready=0, read_valid=0, read_data=0, both bank ids 0, within the same cycle.
- Fill bank 0: write addr a=0..31 with data {4{a+1 as 16b}}, except addr 3 = 64'h0004_0003_0002_0001; pulse write_done -> next cycle read_ready=1, write_ready=1, wr_bank_id=1. Read addr 12..15 -> read_data 1,2,3,4 with read_valid one cycle after each request.
- Both banks full: fill bank 1 and pulse write_done without read_done -> write_ready=0. A write_req to addr 0 with 64'hFFFF... is ignored; reading bank 0 addr 0 returns 16'h0001.
- Swap: read_done with read_ready=1 -> rd_bank_id=1, write_ready=1 next cycle. Reads then return bank-1 data. Assert write_done and read_done in the same cycle -> both pointers toggle and full flags update correctly.
- Read when empty: read_req with read_ready=0 -> read_valid stays 0, read_data holds its previous value. read_done in this state -> no pointer change.
- Streaming: continuous writes and reads every cycle across 4 bank swaps -> zero lost or duplicated slices; scoreboard matches all 4x128 slices.
